// File: rtl/object_placer.sv
// Places NUM_OBJ objects one at a time: random candidate, one frame of collision check, retry or commit.
// Latency per clean object: PICK + wait for frame start + one full frame + COMMIT; done/fail pulse follows.
// No backpressure; abort returns to IDLE from any busy state without a result pulse.
module object_placer #(
    parameter int NUM_OBJ   = 4,
    parameter int MAX_TRIES = 15,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int IDX_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     startOfFrame,
    input  logic [X_W-1:0]           rand_x,
    input  logic [Y_W-1:0]           rand_y,
    input  logic                     collision_any,
    output logic                     busy,
    output logic                     cand_valid,
    output logic [IDX_W-1:0]         cand_idx,
    output logic [X_W-1:0]           cand_x,
    output logic [Y_W-1:0]           cand_y,
    output logic [NUM_OBJ-1:0]       placed_mask,
    output logic [NUM_OBJ*X_W-1:0]   placed_x,
    output logic [NUM_OBJ*Y_W-1:0]   placed_y,
    output logic                     place_done,
    output logic                     place_fail
);

    typedef enum logic [2:0] {
        S_IDLE, S_PICK, S_WAIT_SOF, S_CHECK, S_COMMIT, S_DONE, S_FAIL
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [7:0]               tries_q, tries_d;
    logic                     sticky_q, sticky_d;
    logic [X_W-1:0]           cand_x_q, cand_x_d;
    logic [Y_W-1:0]           cand_y_q, cand_y_d;
    logic [NUM_OBJ-1:0]       mask_q, mask_d;
    logic [NUM_OBJ*X_W-1:0]   px_q, px_d;
    logic [NUM_OBJ*Y_W-1:0]   py_q, py_d;
    logic                     frame_hit;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tries_q  <= '0;
            sticky_q <= 1'b0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            mask_q   <= '0;
            px_q     <= '0;
            py_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tries_q  <= tries_d;
            sticky_q <= sticky_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            mask_q   <= mask_d;
            px_q     <= px_d;
            py_q     <= py_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tries_d   = tries_q;
        sticky_d  = sticky_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        mask_d    = mask_q;
        px_d      = px_q;
        py_d      = py_q;
        // The collision seen on the closing frame pulse still belongs to this frame.
        frame_hit = sticky_q | collision_any;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = '0;
                    idx_d   = '0;
                    tries_d = '0;
                    state_d = S_PICK;
                end
            end
            S_PICK: begin
                // Random source is below twice the range, so one subtraction folds it in.
                cand_x_d = (rand_x > X_W'(X_MAX)) ? rand_x - X_W'(X_MAX + 1) : rand_x;
                cand_y_d = (rand_y > Y_W'(Y_MAX)) ? rand_y - Y_W'(Y_MAX + 1) : rand_y;
                state_d  = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                sticky_d = 1'b0;
                if (startOfFrame) state_d = S_CHECK;
            end
            S_CHECK: begin
                sticky_d = frame_hit;
                if (startOfFrame) begin
                    if (!frame_hit) begin
                        state_d = S_COMMIT;
                    end else if (tries_q == 8'(MAX_TRIES - 1)) begin
                        state_d = S_FAIL;
                    end else begin
                        tries_d = tries_q + 8'd1;
                        state_d = S_PICK;
                    end
                end
            end
            S_COMMIT: begin
                mask_d[idx_q]                   = 1'b1;
                px_d[int'(idx_q) * X_W +: X_W]  = cand_x_q;
                py_d[int'(idx_q) * Y_W +: Y_W]  = cand_y_q;
                tries_d                         = '0;
                if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_PICK;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            mask_d  = '0;
            tries_d = '0;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign cand_valid  = (state_q == S_WAIT_SOF) || (state_q == S_CHECK);
    assign cand_idx    = idx_q;
    assign cand_x      = cand_x_q;
    assign cand_y      = cand_y_q;
    assign placed_mask = mask_q;
    assign placed_x    = px_q;
    assign placed_y    = py_q;
    assign place_done  = (state_q == S_DONE) && !abort;
    assign place_fail  = (state_q == S_FAIL) && !abort;

endmodule
